// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HiLo register pair.
// One shared adder/subtractor is used per iteration; N+1 cycles per operation.
module muldiv_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           is_div_q, is_div_d;
    logic [N-1:0]   mb_q, mb_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic           dz_flag_q, dz_flag_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;

    logic           in_signed;
    logic           b_zero;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic [N-1:0]   dividend;

    logic [N+1:0]   add_x;
    logic [N+1:0]   add_y;
    logic [N+1:0]   add_s;
    logic           borrow;
    logic [N-1:0]   new_rem;

    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;

    assign in_signed = op[0];
    assign b_zero    = (b == '0);
    assign abs_a     = (in_signed && a[N-1]) ? -a : a;
    assign abs_b     = (in_signed && b[N-1]) ? -b : b;
    // Divide by zero runs unsigned on raw a so the remainder comes out as a.
    assign dividend  = b_zero ? a : abs_a;

    // Shared adder: accumulate for multiply, trial-subtract for divide.
    assign add_x  = is_div_q ? {1'b0, acc_q[2*N-1:N-1]}
                             : {2'b00, acc_q[2*N-1:N]};
    assign add_y  = {2'b00, mb_q};
    assign add_s  = add_x + (add_y ^ {(N+2){is_div_q}})
                  + {{(N+1){1'b0}}, is_div_q};
    assign borrow = add_s[N+1];
    assign new_rem = borrow ? acc_q[2*N-2:N-1] : add_s[N-1:0];

    assign prod_fix = negq_q ? -acc_q : acc_q;
    assign quo_fix  = negq_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign rem_fix  = negr_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dz_flag_d = dz_flag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    count_d  = '0;
                    is_div_d = op[1];
                    if (op[1]) begin
                        mb_d      = abs_b;
                        acc_d     = {{N{1'b0}}, dividend};
                        dz_flag_d = b_zero;
                        negq_d    = in_signed && !b_zero && (a[N-1] ^ b[N-1]);
                        negr_d    = in_signed && !b_zero && a[N-1];
                    end else begin
                        mb_d      = abs_a;
                        acc_d     = {{N{1'b0}}, abs_b};
                        dz_flag_d = 1'b0;
                        negq_d    = in_signed && (a[N-1] ^ b[N-1]);
                        negr_d    = 1'b0;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = {new_rem, acc_q[N-2:0], ~borrow};
                end else if (acc_q[0]) begin
                    acc_d = {add_s[N:0], acc_q[N-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*N-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(N-1)) state_d = FIXUP;
            end
            FIXUP: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    lo_d = prod_fix[N-1:0];
                    hi_d = prod_fix[2*N-1:N];
                end
                done_d  = 1'b1;
                dz_d    = dz_flag_q;
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            mb_q      <= '0;
            acc_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            dz_flag_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            dz_flag_q <= dz_flag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic, latency, busy rules, reset abort.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_sequencer #(.N(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy),
        .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op; returns cycles from start edge to done, busy count, dz.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output int bcnt, output logic dz);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = -1;
        dz = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (busy) bcnt++;
            if (done && lat < 0) begin
                lat = j;
                dz = div_by_zero;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rst_hilo got=%h_%h exp=0_0", hi, lo); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        int lat, bc; logic dz;
        run_op(2'b00, 32'hFFFF_FFFF, 32'h2, lat, bc, dz);
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
        total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
        total++; if (lat !== 33) begin bad++; $display("FAIL multu_latency got=%0d exp=33", lat); end
        total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL multu_dz got=%b exp=0", dz); end
    endtask

    task automatic test_mult();
        int lat, bc; logic dz;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc, dz);
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, bc, dz);
        total++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mult_minmin got=%h_%h exp=40000000_00000000", hi, lo); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_div();
        int lat, bc; logic dz;
        run_op(2'b10, 32'd150, 32'd7, lat, bc, dz);
        total++; if (lo !== 32'd21 || hi !== 32'd3) begin bad++; $display("FAIL divu got=lo %h hi %h exp=lo 15 hi 3", lo, hi); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
        total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg got=lo %h hi %h exp=lo fffffffd hi ffffffff", lo, hi); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
        total++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin bad++; $display("FAIL div_ovf got=lo %h hi %h exp=lo 80000000 hi 0", lo, hi); end
        total++; if (lat !== 33 || dz !== 1'b0) begin bad++; $display("FAIL div_ovf_timing got=lat %0d dz %b exp=33 0", lat, dz); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic dz;
        run_op(2'b10, 32'h96, 32'h0, lat, bc, dz);
        total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h96) begin bad++; $display("FAIL divu_zero got=lo %h hi %h exp=lo ffffffff hi 96", lo, hi); end
        total++; if (lat !== 33 || dz !== 1'b1) begin bad++; $display("FAIL divu_zero_flag got=lat %0d dz %b exp=33 1", lat, dz); end
        run_op(2'b11, 32'hFFFF_FFF8, 32'h0, lat, bc, dz);
        total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF8) begin bad++; $display("FAIL div_zero got=lo %h hi %h exp=lo ffffffff hi fffffff8", lo, hi); end
        total++; if (dz !== 1'b1) begin bad++; $display("FAIL div_zero_flag got=%b exp=1", dz); end
    endtask

    task automatic test_busy_rules();
        int lat;
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int j = 1; j <= 40; j++) begin
            if (j == 5) begin a = 32'd100; b = 32'd100; start = 1'b1; end
            if (j == 6) start = 1'b0;
            if (j == 10) begin lo_we = 1'b1; wdata = 32'h1234; end
            if (j == 11) lo_we = 1'b0;
            tick();
            if (done && lat < 0) lat = j;
        end
        total++; if (lo !== 32'd42 || hi !== 32'd0) begin bad++; $display("FAIL busy_ignore got=lo %h hi %h exp=lo 2a hi 0", lo, hi); end
        total++; if (lat !== 33) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=33", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_no_queue got=%b exp=0", busy); end
        lo_we = 1'b1; wdata = 32'h1234;
        tick();
        lo_we = 1'b0;
        total++; if (lo !== 32'h1234 || hi !== 32'h0) begin bad++; $display("FAIL lo_we_idle got=lo %h hi %h exp=lo 1234 hi 0", lo, hi); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        total++; if (hi !== 32'h5555 || lo !== 32'h5555) begin bad++; $display("FAIL both_we got=hi %h lo %h exp=5555 5555", hi, lo); end
    endtask

    task automatic test_start_vs_we();
        op = 2'b00; a = 32'h0001_0000; b = 32'h0003_0000;
        start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        start = 1'b0; hi_we = 1'b0;
        total++; if (hi !== 32'h5555 || busy !== 1'b1) begin bad++; $display("FAIL start_wins_now got=hi %h busy %b exp=5555 1", hi, busy); end
        for (int j = 1; j <= 40; j++) tick();
        total++; if (hi !== 32'h3 || lo !== 32'h0) begin bad++; $display("FAIL start_wins got=hi %h lo %h exp=3 0", hi, lo); end
    endtask

    task automatic test_reset_abort();
        int lat, bc; logic dz; int dn;
        op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 10; j++) tick();
        total++; if (busy !== 1'b1 || hi !== 32'h3) begin bad++; $display("FAIL abort_pre got=busy %b hi %h exp=1 3", busy, hi); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL abort_now got=busy %b hi %h lo %h exp=0 0 0", busy, hi, lo); end
        #2;
        reset = 1'b0;
        dn = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (done || busy) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
        run_op(2'b00, 32'd5, 32'd5, lat, bc, dz);
        total++; if (lo !== 32'd25 || hi !== 32'd0 || lat !== 33) begin bad++; $display("FAIL abort_fresh got=lo %h hi %h lat %0d exp=19 0 33", lo, hi, lat); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_rules();
        test_start_vs_we();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit that owns the CPU's HiLo register pair.
- Sequences MULT/MULTU/DIV/DIVU over N+1 cycles using one shared N-bit adder/subtractor.
- Raises busy so the control unit stalls the pipeline; supports MTHI/MTLO writes when idle.
- Sits beside the ALU in the datapath; the CPU reads HiLo through the hi/lo outputs (MFHI/MFLO).

Parameters:
N, 32, operand and HiLo register width (must be even, >= 4)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  N  rs operand (multiplicand / dividend)
b  input  N  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  N  data for hi_we/lo_we
busy  output  1  operation in progress; CPU must stall HiLo consumers
done  output  1  one-cycle pulse: hi/lo just updated by an operation
div_by_zero  output  1  one-cycle pulse with done when DIV/DIVU had b==0
hi  output  N  Hi register
lo  output  N  Lo register

Behaviour:
- Reset (async, any state): state=IDLE, count=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, internal working registers=0.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 at edge k: latch op; latch |a|, |b| for signed ops (magnitude via two's complement, N-bit), raw a, b for unsigned ops.
  - Record neg_q = a[N-1]^b[N-1] and neg_r = a[N-1] (signed ops only). Set count=0 and go to RUN.
  - busy=1 from after edge k.
- RUN, one iteration per cycle, count increments 0..N-1:
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring shift-subtract, producing an N-bit quotient and an N-bit remainder.
  - When count==N-1, go to FIXUP at the next edge (edge k+N).
- FIXUP (edge k+N+1):
  - Signed ops: negate the 2N-bit product if neg_q; negate the quotient if neg_q and the remainder if neg_r.
  - Write the product to hi=upper N bits, lo=lower N bits, or the division result to lo=quotient, hi=remainder.
  - Pulse done=1 for exactly one cycle, drop busy, return to IDLE.
- Latency: hi/lo and done are valid N+1 cycles after the start edge (33 for N=32). Latency is fixed and independent of operand values.
- Divide by zero (b==0):
  - Full latency is still taken.
  - Result is lo = all ones, hi = a (raw input a, not its magnitude).
  - div_by_zero pulses together with done.
- DIV overflow (a = 0x80000000, b = -1): lo=0x80000000, hi=0. This falls out of magnitude arithmetic truncated to N bits.
- hi/lo are not modified during RUN; old values remain readable until FIXUP.
- start while busy: ignored, with no queueing.
- hi_we/lo_we:
  - Honoured only in IDLE; the write takes effect on the next edge.
  - Ignored while busy or in FIXUP.
  - Both strobes may write in the same cycle.
- start and hi_we/lo_we asserted together in IDLE: start wins; the writes are dropped.
- A new start may be accepted in the cycle done is high, since the state is already IDLE.
- Reset mid-operation: the operation is aborted, hi/lo=0, and no done pulse is produced.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE, done pulses exactly 33 cycles after the start edge, busy high for 33 cycles.
- MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU a=150, b=7 -> lo=21, hi=3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU a=0x96, b=0 -> lo=0xFFFFFFFF, hi=0x96, div_by_zero and done pulse together at cycle 33.
- Busy rules:
  - A second start at cycle 5 is ignored; the result matches the first operands only.
  - lo_we with wdata=0x1234 during busy is ignored.
  - lo_we in IDLE -> lo=0x1234 next cycle.
  - start and hi_we together -> hi gets the product, not wdata.
- Assert reset at cycle 10 of a MULTU -> busy=0, hi=lo=0 immediately. No done pulse follows. A fresh start afterwards completes correctly.
